// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings used by the fetch stage and later pipeline stages
package y86_pkg;
  localparam logic [63:0] PC_RESET = 64'd0;
  localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, CMOVXX = 4'h2, IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7;
  localparam logic [3:0] CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  typedef enum logic [1:0] {AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3} stat_t;
  typedef enum logic [1:0] {FETCH, DONE, HALTED} state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: byte-wide instruction memory port plus the decode-side valid/ready channel
interface fetch_unit_if;
  import y86_pkg::*;
  logic        imem_req, imem_ack, imem_err, fetch_valid, fetch_ready, pc_load;
  logic [63:0] imem_addr, pc_new, valC, valP;
  logic [7:0]  imem_data;
  logic [3:0]  icode, ifun, rA, rB;
  stat_t       stat;
  modport master (
    output imem_req, imem_addr, fetch_valid, icode, ifun, rA, rB, valC, valP, stat,
    input  imem_ack, imem_data, imem_err, fetch_ready, pc_load, pc_new
  );
  modport slave (
    input  imem_req, imem_addr, fetch_valid, icode, ifun, rA, rB, valC, valP, stat,
    output imem_ack, imem_data, imem_err, fetch_ready, pc_load, pc_new
  );
endinterface

// File: rtl/y86_instr_len.sv
// y86_instr_len: icode to instruction shape (validity, register byte, constant, length)
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic       o_valid,
  output logic       o_need_regids,
  output logic       o_need_valc,
  output logic [3:0] o_len
);
  assign o_valid = i_icode <= POPQ;
  assign o_need_regids = i_icode inside {CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ};
  assign o_need_valc = i_icode inside {IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL};
  assign o_len = 4'd1 + (o_need_regids ? 4'd1 : 4'd0) + (o_need_valc ? 4'd8 : 4'd0);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle Y86-64 fetch stage reading one instruction byte per memory handshake
module fetch_unit
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  state_t      r_state, w_state;
  stat_t       r_stat, w_stat;
  logic [63:0] r_pc, w_pc, r_addr, w_addr, r_valc, w_valc, r_valp, w_valp;
  logic [3:0]  r_cnt, w_cnt, r_icode, w_icode, r_ifun, w_ifun, r_ra, w_ra, r_rb, w_rb;
  logic [3:0]  w_len_icode, w_len;
  logic [2:0]  w_vidx;
  logic        r_req, w_req, r_valid, w_valid, w_ack, w_ok, w_regids, w_has_valc, w_last;

  assign w_ack = r_state == FETCH && r_req && bus.imem_ack;
  assign w_len_icode = (r_cnt == 4'd0 && !bus.imem_err) ? bus.imem_data[7:4] : r_icode;
  assign w_last = bus.imem_err || !w_ok || r_cnt + 4'd1 == w_len;
  assign w_vidx = r_cnt[2:0] - (w_regids ? 3'd2 : 3'd1);

  y86_instr_len u_len (
    .i_icode       (w_len_icode),
    .o_valid       (w_ok),
    .o_need_regids (w_regids),
    .o_need_valc   (w_has_valc),
    .o_len         (w_len)
  );

  // next state: byte capture while fetching, PC update and field reset on accept
  always_comb begin
    w_state = r_state;
    w_stat  = r_stat;
    w_pc    = r_pc;
    w_addr  = r_addr;
    w_cnt   = r_cnt;
    w_req   = r_req;
    w_valid = r_valid;
    w_icode = r_icode;
    w_ifun  = r_ifun;
    w_ra    = r_ra;
    w_rb    = r_rb;
    w_valc  = r_valc;
    w_valp  = r_valp;
    if (w_ack) begin
      if (bus.imem_err) w_stat = ADR;
      else if (r_cnt == 4'd0) begin
        w_icode = bus.imem_data[7:4];
        w_ifun  = bus.imem_data[3:0];
        w_stat  = !w_ok ? INS : bus.imem_data[7:4] == HALT ? HLT : AOK;
      end else if (w_regids && r_cnt == 4'd1) begin
        w_ra = bus.imem_data[7:4];
        w_rb = bus.imem_data[3:0];
      end else if (w_has_valc) w_valc[{w_vidx, 3'b000} +: 8] = bus.imem_data;
      if (w_last) begin
        w_state = DONE;
        w_req   = 1'b0;
        w_valid = 1'b1;
        w_valp  = r_pc + {60'd0, w_len};
      end else begin
        w_cnt  = r_cnt + 4'd1;
        w_addr = r_pc + {60'd0, r_cnt + 4'd1};
      end
    end else if (r_state == FETCH) w_req = 1'b1;
    else if (r_state == DONE && bus.fetch_ready) begin
      w_valid = 1'b0;
      if (r_stat != AOK) w_state = HALTED;
      else begin
        w_state = FETCH;
        w_pc    = bus.pc_load ? bus.pc_new : r_valp;
        w_addr  = bus.pc_load ? bus.pc_new : r_valp;
        w_cnt   = 4'd0;
        w_icode = HALT;
        w_ifun  = 4'h0;
        w_ra    = REG_NONE;
        w_rb    = REG_NONE;
        w_valc  = 64'd0;
      end
    end
  end

  // state register; every output comes straight from here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_stat  <= AOK;
      r_pc    <= PC_RESET;
      r_addr  <= PC_RESET;
      r_cnt   <= 4'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_icode <= HALT;
      r_ifun  <= 4'h0;
      r_ra    <= REG_NONE;
      r_rb    <= REG_NONE;
      r_valc  <= 64'd0;
      r_valp  <= 64'd0;
    end else begin
      r_state <= w_state;
      r_stat  <= w_stat;
      r_pc    <= w_pc;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_req   <= w_req;
      r_valid <= w_valid;
      r_icode <= w_icode;
      r_ifun  <= w_ifun;
      r_ra    <= w_ra;
      r_rb    <= w_rb;
      r_valc  <= w_valc;
      r_valp  <= w_valp;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.fetch_valid = r_valid;
  assign bus.icode       = r_icode;
  assign bus.ifun        = r_ifun;
  assign bus.rA          = r_ra;
  assign bus.rB          = r_rb;
  assign bus.valC        = r_valc;
  assign bus.valP        = r_valp;
  assign bus.stat        = r_stat;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and scoreboarded checks of the fetch stage against a byte memory model
module tb_fetch_unit;
  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
  } exp_t;

  typedef struct {
    logic [79:0] bytes;
    int          len;
    exp_t        e;
  } vec_t;

  localparam int NV = 12;
  localparam exp_t RST_E = '{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic        err_en = 1'b0;
  logic [63:0] err_addr = 64'd0;
  bit          rand_mode = 1'b0, chk_stable = 1'b0, stray = 1'b0;
  int          wait_left = 0;
  int          checks = 0, errors = 0;
  exp_t        exp_q [$];
  vec_t        vt [NV];

  assign bus.imem_ack  = (bus.imem_req && wait_left == 0) || stray;
  assign bus.imem_data = mem[bus.imem_addr[7:0]];
  assign bus.imem_err  = err_en && bus.imem_addr == err_addr;

  always @(posedge clk)
    if (bus.imem_req && bus.imem_ack) wait_left <= rand_mode ? int'($urandom_range(0, 5)) : 0;
    else if (wait_left > 0) wait_left <= wait_left - 1;

  task automatic chk(input bit ok, input string name, input logic [145:0] act, input logic [145:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [63:0] p_addr = 64'd0;
  always @(negedge clk) begin
    if (chk_stable && p_req && !p_ack && bus.imem_req)
      chk(bus.imem_addr == p_addr, "addr_stable", 146'(bus.imem_addr), 146'(p_addr));
    p_req  = bus.imem_req;
    p_ack  = bus.imem_ack;
    p_addr = bus.imem_addr;
  end

  function automatic exp_t got();
    return {bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP, bus.stat};
  endfunction

  function automatic vec_t mk(input logic [79:0] b, input int l, input logic [3:0] ic, fn, a, rb,
                              input logic [63:0] c, p, input logic [1:0] s);
    vec_t v;
    v.bytes = b;
    v.len   = l;
    v.e     = '{ic, fn, a, rb, c, p, s};
    return v;
  endfunction

  task automatic fill();
    foreach (mem[i]) mem[i] = 8'h10;
  endtask

  task automatic load(input logic [79:0] b, input int base);
    for (int i = 0; i < 10; i++) mem[8'(base + i)] = b[79 - 8 * i -: 8];
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 1'b0;
    err_en = 1'b0;
    stray = 1'b0;
    exp_q.delete();
    @(negedge clk);
    if (check) begin
      chk(got() === RST_E, "reset_fields", got(), RST_E);
      chk({bus.imem_req, bus.fetch_valid, bus.imem_addr} === 66'd0, "reset_ctl",
          146'({bus.imem_req, bus.fetch_valid, bus.imem_addr}), 146'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fetch_valid && n < max);
    chk(bus.fetch_valid, "valid_timeout", 146'(n), 146'(max));
  endtask

  task automatic pop_cmp(input string name);
    exp_t e;
    chk(exp_q.size() != 0, {name, "_sb_empty"}, 146'(exp_q.size()), 146'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(got() === e, name, got(), e);
    end
  endtask

  task automatic accept(input bit ld, input logic [63:0] np, input logic [63:0] exp_addr, input bit aok);
    bus.fetch_ready = 1'b1;
    bus.pc_load = ld;
    bus.pc_new = np;
    @(negedge clk);
    bus.fetch_ready = 1'b0;
    bus.pc_load = 1'b0;
    stray = 1'b1;
    chk(!bus.fetch_valid && !bus.imem_req, "bubble", 146'({bus.fetch_valid, bus.imem_req}), 146'(0));
    @(negedge clk);
    if (aok) begin
      stray = 1'b0;
      chk(bus.imem_req && bus.imem_addr == exp_addr, "next_addr",
          146'({bus.imem_req, bus.imem_addr}), 146'({1'b1, exp_addr}));
    end else begin
      repeat (4) @(negedge clk);
      stray = 1'b0;
      chk(!bus.imem_req && !bus.fetch_valid, "halted", 146'({bus.imem_req, bus.fetch_valid}), 146'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n, pops;
    bit late_req;
    bus.fetch_ready = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_new = 64'd0;
    vt[0]  = mk(80'h30F30A00000000000000, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 2'd0);
    vt[1]  = mk(80'h60230000000000000000, 2, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 2'd0);
    vt[2]  = mk(80'h00000000000000000000, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 2'd1);
    vt[3]  = mk(80'hC0000000000000000000, 1, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 2'd3);
    vt[4]  = mk(80'h70112233445566778800, 9, 4'h7, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'd9, 2'd0);
    vt[5]  = mk(80'h83000100000000000000, 9, 4'h8, 4'h3, 4'hF, 4'hF, 64'h100, 64'd9, 2'd0);
    vt[6]  = mk(80'h90000000000000000000, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 2'd0);
    vt[7]  = mk(80'h4015FFFFFFFFFFFFFFFF, 10, 4'h4, 4'h0, 4'h1, 4'h5, 64'hFFFFFFFFFFFFFFFF, 64'd10, 2'd0);
    vt[8]  = mk(80'hA02F0000000000000000, 2, 4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 64'd2, 2'd0);
    vt[9]  = mk(80'h21450000000000000000, 2, 4'h2, 4'h1, 4'h4, 4'h5, 64'd0, 64'd2, 2'd0);
    vt[10] = mk(80'h5267EFCDAB8967452301, 10, 4'h5, 4'h2, 4'h6, 4'h7, 64'h0123456789ABCDEF, 64'd10, 2'd0);
    vt[11] = mk(80'hB03F0000000000000000, 2, 4'hB, 4'h0, 4'h3, 4'hF, 64'd0, 64'd2, 2'd0);

    for (int i = 0; i < NV; i++) begin
      fill();
      load(vt[i].bytes, 0);
      do_reset(i == 0);
      exp_q.push_back(vt[i].e);
      wait_valid(40, n);
      chk(n == vt[i].len + 1, "latency", 146'(n), 146'(vt[i].len + 1));
      pop_cmp("table");
      accept(1'b0, 64'd0, vt[i].e.valp, vt[i].e.stat == 2'd0);
    end

    fill();
    load(80'h60230000000000000000, 0);
    bus.fetch_ready = 1'b1;
    do_reset(1'b0);
    exp_q.push_back('{4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 2'd0});
    exp_q.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd3, 2'd1});
    pops = 0;
    late_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pops == 2 && bus.imem_req) late_req = 1'b1;
      if (bus.fetch_valid) begin
        pop_cmp("addq_halt");
        pops++;
      end
    end
    bus.fetch_ready = 1'b0;
    chk(pops == 2, "addq_halt_count", 146'(pops), 146'(2));
    chk(!late_req, "req_after_halt", 146'(late_req), 146'(0));

    fill();
    mem[8'h40] = 8'h90;
    mem[8'hFF] = 8'h60;
    do_reset(1'b0);
    exp_q.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 2'd0});
    wait_valid(40, n);
    pop_cmp("nop");
    accept(1'b1, 64'h40, 64'h40, 1'b1);
    bus.pc_load = 1'b1;
    bus.pc_new = 64'h80;
    exp_q.push_back('{4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 2'd0});
    wait_valid(40, n);
    repeat (2) @(negedge clk);
    pop_cmp("ret_at_40");
    accept(1'b0, 64'd0, 64'h41, 1'b1);
    exp_q.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h42, 2'd0});
    wait_valid(40, n);
    pop_cmp("nop_at_41");
    accept(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    exp_q.push_back('{4'h6, 4'h0, 4'h1, 4'h0, 64'd0, 64'd1, 2'd0});
    wait_valid(40, n);
    pop_cmp("wrap");
    accept(1'b0, 64'd0, 64'd1, 1'b1);

    fill();
    load(80'h70112233445566778899, 0);
    do_reset(1'b0);
    err_en = 1'b1;
    err_addr = 64'd3;
    exp_q.push_back('{4'h7, 4'h0, 4'hF, 4'hF, 64'h2211, 64'd9, 2'd2});
    wait_valid(40, n);
    chk(n == 5, "adr_latency", 146'(n), 146'(5));
    pop_cmp("jxx_adr");
    accept(1'b0, 64'd0, 64'd0, 1'b0);

    fill();
    load(vt[0].bytes, 0);
    load(vt[7].bytes, 10);
    rand_mode = 1'b1;
    do_reset(1'b0);
    chk_stable = 1'b1;
    exp_q.push_back(vt[0].e);
    exp_q.push_back('{4'h4, 4'h0, 4'h1, 4'h5, 64'hFFFFFFFFFFFFFFFF, 64'd20, 2'd0});
    wait_valid(200, n);
    pop_cmp("rand_irmovq");
    accept(1'b0, 64'd0, 64'd10, 1'b1);
    wait_valid(200, n);
    pop_cmp("rand_rmmovq");
    accept(1'b0, 64'd0, 64'd20, 1'b1);
    chk_stable = 1'b0;
    rand_mode = 1'b0;
    repeat (8) @(negedge clk);

    fill();
    load(vt[0].bytes, 0);
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(got() === RST_E, "midfetch_reset_fields", got(), RST_E);
    chk({bus.imem_req, bus.fetch_valid, bus.imem_addr} === 66'd0, "midfetch_reset_ctl",
        146'({bus.imem_req, bus.fetch_valid, bus.imem_addr}), 146'(0));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle Y86-64 fetch stage: owns the PC and reads one instruction byte per handshake from a byte-wide instruction memory port. It assembles icode, ifun, rA, rB, valC and valP, then presents them to decode/write-back through a valid/ready handshake. Next PC is valP unless the downstream stages redirect with pc_load. Invalid opcodes, halt and memory errors are reported as a status code, and the stage then stops fetching.

## Interface
- PC_RESET, 64'd0: PC value after reset.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  byte read request; held until imem_ack.
- imem_addr  out  64  byte address; stable while imem_req is high.
- imem_ack  in  1  one-cycle acknowledge; imem_data and imem_err are valid in this cycle. May be high in the same cycle as imem_req.
- imem_data  in  8  returned byte.
- imem_err  in  1  address error, qualified by imem_ack.
- fetch_valid  out  1  instruction fields valid.
- fetch_ready  in  1  downstream accepts the instruction.
- pc_load  in  1  redirect; sampled only in the accept cycle.
- pc_new  in  64  redirect target.
- icode, ifun  out  4 each  from byte0[7:4] and byte0[3:0].
- rA, rB  out  4 each  from byte1[7:4] and byte1[3:0]; 4'hF when the instruction has no register byte.
- valC  out  64  little-endian constant; 0 when absent.
- valP  out  64  PC + instruction length, modulo 2^64.
- stat  out  2  0 = AOK, 1 = HLT, 2 = ADR, 3 = INS.

## Operation
- Instruction lengths by icode:
  - 1 byte: 0 halt, 1 nop, 9 ret.
  - 2 bytes: 2 cmovxx, 6 OPq, A pushq, B popq.
  - 9 bytes: 7 jXX, 8 call.
  - 10 bytes: 3 irmovq, 4 rmmovq, 5 mrmovq.
- Byte layout:
  - Register byte follows byte0 for icodes 2–6 and A–B.
  - valC occupies the last 8 bytes for icodes 3, 4, 5, 7, 8.
- FSM states and transitions:
  - FETCH: requests bytes at pc+cnt, where cnt runs 0..len-1. On each ack the byte is captured and cnt increments. After the ack of byte len-1, go to DONE.
  - DONE: fetch_valid=1, all fields held stable, imem_req=0. On fetch_valid & fetch_ready:
    - If stat≠AOK, go to HALTED.
    - Otherwise load pc ← (pc_load ? pc_new : valP), set cnt ← 0, clear valC to 0, and return to FETCH.
  - HALTED: no requests, fetch_valid=0. Only reset exits this state.
- Boundary conditions:
  - icode > 4'hB on byte0 ack: stat=INS, go to DONE immediately, len=1, valP=pc+1.
  - icode 0 (halt): stat=HLT, len 1.
  - imem_err on any ack: stat=ADR, go to DONE at that edge. The remaining fields keep the bytes captured so far; uncaptured fields keep their defaults. valP=pc+len is computed as if the fetch had completed.
  - pc_load outside the accept cycle is ignored.
  - imem_ack with imem_req low is ignored.
  - PC and address arithmetic wrap modulo 2^64. pc=64'hFFFF_FFFF_FFFF_FFFF with a 2-byte instruction gives second address 0 and valP=1.

## Timing
- All outputs are registered.
- Reset values (asynchronous, while rst_n is low): state FETCH, pc=PC_RESET, cnt 0, imem_req 0, imem_addr PC_RESET, fetch_valid 0, icode 0, ifun 0, rA F, rB F, valC 0, valP 0, stat AOK.
- imem_req rises on the first posedge after rst_n deasserts.
- Between bytes imem_req stays high. imem_addr advances on the ack edge.
- After the final ack, imem_req falls and fetch_valid rises on the same edge.
- With zero-wait memory, an L-byte instruction has fetch_valid high L+1 cycles after the first req cycle.
- The accept edge clears fetch_valid. The next req starts in the following cycle, so there is one bubble cycle per instruction.
- Reset mid-fetch or mid-DONE discards the instruction; no partial-field output survives.

## Structure
- Package y86_pkg holds:
  - icode constants: HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - stat encoding.
  - REG_NONE = 4'hF.
- Sub-module y86_instr_len: combinational, icode → {valid, need_regids, need_valC, len[3:0]}. It is shared with later pipeline work.
- fetch_unit itself contains the FSM, PC, byte counter and field capture registers.

## Test plan
- Reset release, memory at 0 = 30 F3 0A 00 00 00 00 00 00 00 (irmovq $10,%rbx), ack every cycle → fetch_valid in the 11th cycle with icode 3, ifun 0, rA F, rB 3, valC 10, valP 10, stat AOK.
- Memory 60 23 then 00 (addq, then halt), ready tied high → first instruction: icode 6, rA 2, rB 3, valP 2. Second: stat HLT, valP 3. Then no further imem_req.
- Accept with pc_load=1, pc_new=0x40 → next imem_addr is 0x40, not valP.
- Byte0 = 0xC0 → stat INS, len 1, valP=pc+1, and the unit halts after accept.
- imem_err on the 4th byte of a jXX → stat ADR with fetch_valid on the next edge. Separately: random ack delays of 0–5 cycles hold imem_addr stable. Separately: rst_n low mid-valC clears all outputs to their reset values immediately.
